// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deserialises
// device-to-host frames, tracks shift/break/extended state and emits ASCII keypresses.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic        Keypress,
    output logic [15:0] KeyData,
    output logic        FrameError
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES);

    logic           clk_meta, clk_sync, data_meta, data_sync;
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    logic [TCW-1:0] to_cnt;
    logic           timeout;
    state_t         state, next_state;
    logic [7:0]     shreg;
    logic [2:0]     bit_cnt;
    logic           par_q;
    logic           frame_ok, frame_bad;
    logic           byte_valid;
    logic           shift, break_pending, ext_pending;
    logic [7:0]     ascii;

    // Synchronisers idle high, matching the released PS/2 bus.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK;
            clk_sync  <= clk_meta;
            data_meta <= PS2_DATA;
            data_sync <= data_meta;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_MAX) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall = clk_filt && !clk_sync && (filt_cnt == FILT_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                             to_cnt <= '0;
        else if (fall || state == IDLE || timeout) to_cnt <= '0;
        else                                      to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state != IDLE) && (to_cnt == TO_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_sync) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            frame_bad = 1'b1;
        end else if (state == STOP && fall) begin
            if (data_sync && (^{shreg, par_q})) frame_ok  = 1'b1;
            else                                frame_bad = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE:   bit_cnt <= '0;
                DATA: begin
                    shreg   <= {data_sync, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: par_q <= data_sync;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            byte_valid <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            byte_valid <= frame_ok;
            FrameError <= frame_bad;
        end
    end

    function automatic logic [7:0] translate(input logic [7:0] code, input logic shifted);
        logic [7:0] ch;
        logic       letter;
        ch     = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
                    8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
                    8'h3E: ch = "8";  8'h46: ch = "9";
                    8'h29: ch = 8'h20; 8'h5A: ch = 8'h0A; 8'h66: ch = 8'h08;
                    8'h0D: ch = 8'h09; 8'h76: ch = 8'h1B;
                    default: ch = 8'h00;
                endcase
            end
        endcase
        return (letter && shifted) ? ch - 8'h20 : ch;
    endfunction

    assign ascii = translate(shreg, shift);

    // Timeouts never reach here, so modifier state survives an abandoned frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift         <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            Keypress      <= 1'b0;
            KeyData       <= 16'h0000;
        end else begin
            Keypress <= 1'b0;
            if (byte_valid) begin
                case (shreg)
                    8'hE0: ext_pending   <= 1'b1;
                    8'hF0: break_pending <= 1'b1;
                    8'h12, 8'h59: begin
                        shift         <= !break_pending;
                        break_pending <= 1'b0;
                        ext_pending   <= 1'b0;
                    end
                    default: begin
                        if (ext_pending || break_pending) begin
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end else if (ascii != 8'h00) begin
                            Keypress <= 1'b1;
                            KeyData  <= {8'h00, ascii};
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver feeding the memory-mapped keyboard registers (KBSR/KBDR) of the memory control unit.
- Deserialises PS/2 device-to-host frames and tracks make/break/shift state.
- Translates Set-2 scancodes to ASCII.
- Presents each printable or control keypress as a one-cycle Keypress strobe plus a held 16-bit data word, which map directly onto the Keypress and Data_FromKeyboard inputs of the memory control unit.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised PS2_CLK samples required before the filtered clock changes level.
TIMEOUT_CYCLES, 50000, Clk cycles without a filtered PS2_CLK falling edge before a partial frame is abandoned.

Ports:
Clk  in  1  system clock; all state is on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
PS2_CLK  in  1  raw keyboard clock, asynchronous.
PS2_DATA  in  1  raw keyboard data, asynchronous.
Keypress  out  1  one-cycle strobe: a new translated key is on KeyData.
KeyData  out  16  {8'h00, ASCII}; held until the next Keypress.
FrameError  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n). Reset clears all state.
  - Keypress=0, KeyData=16'h0000, FrameError=0.
  - FSM=IDLE, shift=0, break_pending=0, ext_pending=0.
  - Filtered clock=1, timeout counter=0.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser.
  - Filter: the filtered clock changes only after FILTER_LEN consecutive equal samples.
  - fall strobe: one cycle when the filtered clock goes 1->0. PS2_DATA (synchronised) is sampled on fall.
- Frame FSM (states IDLE, DATA, PARITY, STOP); all transitions occur on fall only.
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (spurious start, no error).
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: always -> IDLE.
    - Frame is valid if ones(data)+parity is odd AND stop=1; valid asserts the byte_valid strobe next cycle.
    - Otherwise FrameError pulses next cycle and the byte is discarded.
- Timeout:
  - The counter clears on every fall and on IDLE.
  - Reaching TIMEOUT_CYCLES in a non-IDLE state forces IDLE and pulses FrameError for one cycle.
  - Decoder state (shift, pending flags) is not affected by a timeout.
- Decoder (acts on byte_valid):
  - 8'hE0: ext_pending=1.
  - 8'hF0: break_pending=1.
  - 8'h12 or 8'h59 (L/R shift): shift = !break_pending; clear both pending flags.
  - Any other byte:
    - If ext_pending or break_pending: discard and clear both flags.
    - Else: translate. A nonzero result asserts Keypress and loads KeyData on the same rising edge. A zero result is ignored.
- Latency: the Keypress cycle is exactly 2 Clk cycles after the fall cycle that sampled the stop bit.
- Translation table (Set 2):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. shift=1 gives uppercase (ASCII -0x20).
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Controls: 29 0x20, 5A 0x0A, 66 0x08, 0D 0x09, 76 0x1B.
  - Digits and controls ignore shift. All other codes translate to 0.
- Output guarantees:
  - KeyData is never 16'h0000 while Keypress=1.
  - KeyData is stable between strobes, so downstream may load it at any later cycle.
- Reset mid-frame: abandons the partial frame; no Keypress and no FrameError is produced for it.

Test Plan:
- Reset: Reset_n low mid-frame -> Keypress=0, KeyData=0000, FrameError=0. After release, the frame for 1C gives KeyData=0061 with Keypress one cycle, exactly 2 cycles after the stop-bit fall.
- Shift/break: send 12, 1C, F0 1C, F0 12, 1C -> Keypress twice, KeyData 0041 then 0061. The break sequences produce no Keypress.
- Parity error: byte 1C with parity=1 (even total) -> FrameError one cycle, no Keypress, KeyData unchanged. The next good 32 gives 0062.
- Stop-bit error: stop bit=0 -> FrameError pulse, FSM back to IDLE. A following good frame decodes normally.
- Timeout: start bit plus 3 data bits, then PS2_CLK held high for TIMEOUT_CYCLES -> FrameError pulse and FSM=IDLE. A subsequent 45 gives KeyData=0030.
- Extended/unmapped/glitch: E0 75, then E0 F0 75, then unmapped 05 -> no Keypress. A PS2_CLK glitch shorter than FILTER_LEN cycles -> no bit sampled.
